// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chess_pkg
//  Brief    : Shared figure codes, FSM states, board type and start position
//             for the chess move controller.
//  Revision : 1.0 - initial release
// ============================================================================
package chess_pkg;

  // Figure codes: white 1..6, black 7..12 in the same piece order.
  typedef enum logic [3:0] {
    FIG_EMPTY   = 4'd0,
    FIG_WPAWN   = 4'd1,
    FIG_WBISHOP = 4'd2,
    FIG_WKNIGHT = 4'd3,
    FIG_WROOK   = 4'd4,
    FIG_WQUEEN  = 4'd5,
    FIG_WKING   = 4'd6,
    FIG_BPAWN   = 4'd7,
    FIG_BBISHOP = 4'd8,
    FIG_BKNIGHT = 4'd9,
    FIG_BROOK   = 4'd10,
    FIG_BQUEEN  = 4'd11,
    FIG_BKING   = 4'd12
  } fig_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_SELECTED = 3'd2,
    ST_EXEC     = 3'd3,
    ST_CASTLE   = 3'd4
  } state_t;

  // board[row][col], row 0 is the black back rank.
  typedef logic [7:0][7:0][3:0] board_t;

  function automatic logic is_white(input logic [3:0] code);
    return (code >= FIG_WPAWN) && (code <= FIG_WKING);
  endfunction

  function automatic logic is_black(input logic [3:0] code);
    return (code >= FIG_BPAWN) && (code <= FIG_BKING);
  endfunction

  // Packed rows are written col7 first, so they read mirrored here.
  function automatic board_t init_board();
    board_t b;
    b    = '0;
    b[0] = {4'hA, 4'h9, 4'h8, 4'hC, 4'hB, 4'h8, 4'h9, 4'hA};
    b[1] = {8{4'h7}};
    b[6] = {8{4'h1}};
    b[7] = {4'h4, 4'h3, 4'h2, 4'h6, 4'h5, 4'h2, 4'h3, 4'h4};
    return b;
  endfunction

  localparam board_t INIT_BOARD = init_board();

endpackage
`default_nettype wire

// File: rtl/chess_board_reg.sv
`default_nettype none
// ============================================================================
//  Module   : chess_board_reg
//  Brief    : 64 x 4-bit board register file, resets to the start position,
//             two synchronous write ports (B wins on clash), full parallel read.
//  Revision : 1.0 - initial release
// ============================================================================
module chess_board_reg
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we_a,
  input  logic [5:0] addr_a,
  input  logic [3:0] data_a,
  input  logic       we_b,
  input  logic [5:0] addr_b,
  input  logic [3:0] data_b,
  output board_t     board
);

  // Board storage; port B is written last so it overrides port A on the same square.
  always_ff @(posedge clk) begin
    if (rst) begin
      board <= INIT_BOARD;
    end else begin
      if (we_a) board[addr_a[5:3]][addr_a[2:0]] <= data_a;
      if (we_b) board[addr_b[5:3]][addr_b[2:0]] <= data_b;
    end
  end

endmodule
`default_nettype wire

// File: rtl/move_controller.sv
`default_nettype none
// ============================================================================
//  Module   : move_controller
//  Brief    : Click-driven selection / move execution around figure_move_logic,
//             including promotion and castling rook relocation.
//  Revision : 1.0 - initial release
// ============================================================================
module move_controller
  import chess_pkg::*;
#(
  parameter int MASK_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        click_valid,
  input  logic [5:0]  click_pos,
  input  logic [63:0] possible_moves,
  output board_t      board,
  output logic [3:0]  selected_figure,
  output logic [5:0]  position,
  output logic [63:0] highlight,
  output logic        turn,
  output logic        move_done,
  output logic        illegal
);

  localparam int CNT_W = (MASK_LATENCY < 2) ? 1 : $clog2(MASK_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MASK_LATENCY - 1);

  state_t           state, state_n;
  logic [5:0]       src, src_n, dst, dst_n;
  logic [3:0]       fig, fig_n;
  logic [63:0]      moves_q, moves_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             turn_n, done_n, illegal_n;

  logic             we_a, we_b;
  logic [5:0]       addr_a, addr_b;
  logic [3:0]       data_a, data_b;

  logic [3:0]       click_fig;
  logic             click_own;
  logic [3:0]       placed_fig;
  logic             is_castle;
  logic [5:0]       rook_from, rook_to;
  logic [3:0]       rook_fig;

  chess_board_reg u_board (
    .clk    (clk),
    .rst    (rst),
    .we_a   (we_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .we_b   (we_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .board  (board)
  );

  // Promotion and castling decode from the latched move.
  always_comb begin
    click_fig  = board[click_pos[5:3]][click_pos[2:0]];
    click_own  = turn ? is_black(click_fig) : is_white(click_fig);
    placed_fig = fig;
    if (fig == FIG_WPAWN && dst[5:3] == 3'd0) placed_fig = FIG_WQUEEN;
    if (fig == FIG_BPAWN && dst[5:3] == 3'd7) placed_fig = FIG_BQUEEN;
    is_castle = 1'b0;
    rook_from = 6'd0;
    rook_to   = 6'd0;
    rook_fig  = (fig == FIG_WKING) ? FIG_WROOK : FIG_BROOK;
    if (fig == FIG_WKING && src == 6'd60) begin
      if (dst == 6'd62) begin is_castle = 1'b1; rook_from = 6'd63; rook_to = 6'd61; end
      if (dst == 6'd58) begin is_castle = 1'b1; rook_from = 6'd56; rook_to = 6'd59; end
    end
    if (fig == FIG_BKING && src == 6'd4) begin
      if (dst == 6'd6) begin is_castle = 1'b1; rook_from = 6'd7; rook_to = 6'd5; end
      if (dst == 6'd2) begin is_castle = 1'b1; rook_from = 6'd0; rook_to = 6'd3; end
    end
  end

  // Next-state logic and board write control.
  always_comb begin
    state_n   = state;
    src_n     = src;
    dst_n     = dst;
    fig_n     = fig;
    moves_n   = moves_q;
    cnt_n     = cnt;
    turn_n    = turn;
    done_n    = 1'b0;
    illegal_n = 1'b0;
    we_a      = 1'b0;
    addr_a    = src;
    data_a    = FIG_EMPTY;
    we_b      = 1'b0;
    addr_b    = dst;
    data_b    = placed_fig;
    case (state)
      ST_IDLE: begin
        if (click_valid && click_own) begin
          src_n   = click_pos;
          fig_n   = click_fig;
          cnt_n   = '0;
          state_n = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          moves_n = possible_moves;
          state_n = ST_SELECTED;
        end
      end
      ST_SELECTED: begin
        if (click_valid) begin
          if (click_pos == src) begin
            state_n = ST_IDLE;
          end else if (click_own) begin
            src_n   = click_pos;
            fig_n   = click_fig;
            cnt_n   = '0;
            state_n = ST_LOOKUP;
          end else if (moves_q[click_pos]) begin
            dst_n   = click_pos;
            state_n = ST_EXEC;
          end else begin
            illegal_n = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        we_a = 1'b1;
        we_b = 1'b1;
        if (is_castle) begin
          state_n = ST_CASTLE;
        end else begin
          turn_n  = ~turn;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_CASTLE: begin
        we_a    = 1'b1;
        addr_a  = rook_from;
        we_b    = 1'b1;
        addr_b  = rook_to;
        data_b  = rook_fig;
        turn_n  = ~turn;
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      src       <= '0;
      dst       <= '0;
      fig       <= '0;
      moves_q   <= '0;
      cnt       <= '0;
      turn      <= 1'b0;
      move_done <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_n;
      src       <= src_n;
      dst       <= dst_n;
      fig       <= fig_n;
      moves_q   <= moves_n;
      cnt       <= cnt_n;
      turn      <= turn_n;
      move_done <= done_n;
      illegal   <= illegal_n;
    end
  end

  // Selection view: figure only while something is selected, position holds.
  always_comb begin
    selected_figure = (state == ST_IDLE) ? 4'd0 : fig;
    position        = src;
    highlight       = (state == ST_SELECTED) ? moves_q : 64'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_move_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_controller
//  Brief    : Directed bench for move_controller with a pulse scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_move_controller;

  typedef logic [7:0][7:0][3:0] brd_t;

  typedef struct {
    bit   kind;   // 0 = move_done, 1 = illegal
    int   cyc;
    brd_t b;
    logic t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        click_valid = 1'b0;
  logic [5:0]  click_pos = 6'd0;
  logic [63:0] possible_moves = 64'd0;
  brd_t        board;
  logic [3:0]  selected_figure;
  logic [5:0]  position;
  logic [63:0] highlight;
  logic        turn;
  logic        move_done;
  logic        illegal;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  brd_t mb;
  logic exp_turn;
  int   dummy;

  move_controller #(.MASK_LATENCY(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .click_valid     (click_valid),
    .click_pos       (click_pos),
    .possible_moves  (possible_moves),
    .board           (board),
    .selected_figure (selected_figure),
    .position        (position),
    .highlight       (highlight),
    .turn            (turn),
    .move_done       (move_done),
    .illegal         (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (move_done || illegal) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: move_done=%0b illegal=%0b at cycle %0d, required no pulse",
                 move_done, illegal, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (move_done !== !e.kind || illegal !== e.kind || cyc != e.cyc ||
            board !== e.b || turn !== e.t) begin
          errors++;
          $display("FAIL pulse_event: got done=%0b ill=%0b cyc=%0d turn=%0b board=%h, required kind=%0d cyc=%0d turn=%0b board=%h",
                   move_done, illegal, cyc, turn, board, e.kind, e.cyc, e.t, e.b);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic init_model();
    logic [3:0] back_b [8];
    logic [3:0] back_w [8];
    back_b = '{4'hA, 4'h9, 4'h8, 4'hB, 4'hC, 4'h8, 4'h9, 4'hA};
    back_w = '{4'h4, 4'h3, 4'h2, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4};
    mb = '0;
    for (int c = 0; c < 8; c++) begin
      mb[0][c] = back_b[c];
      mb[1][c] = 4'h7;
      mb[6][c] = 4'h1;
      mb[7][c] = back_w[c];
    end
    exp_turn = 1'b0;
  endtask

  task automatic set_sq(input logic [5:0] p, input logic [3:0] v);
    mb[p[5:3]][p[2:0]] = v;
  endtask

  task automatic push(input bit kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.b    = mb;
    e.t    = exp_turn;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    init_model();
  endtask

  // Returns the cycle count just after the edge that sampled the click.
  task automatic click(input logic [5:0] p, output int ce);
    @(posedge clk);
    #1 click_valid = 1'b1;
    click_pos = p;
    @(posedge clk);
    #1 click_valid = 1'b0;
    ce = cyc;
  endtask

  task automatic check_start(input string tag);
    chk({tag, "_board"}, board, mb);
    chk({tag, "_turn"}, turn, 1'b0);
    chk({tag, "_sel"}, selected_figure, 4'd0);
    chk({tag, "_highlight"}, highlight, 64'd0);
  endtask

  task automatic move(input logic [5:0] s, input logic [5:0] d, input logic [3:0] f,
                      input logic [3:0] placed, input bit castle,
                      input logic [5:0] rf, input logic [5:0] rt, input logic [3:0] rc);
    int ce;
    possible_moves = 64'd1 << d;
    click(s, ce);
    chk("sel_fig", selected_figure, f);
    chk("position", position, s);
    repeat (2) @(posedge clk);
    #1;
    chk("highlight", highlight, 64'd1 << d);
    click(d, ce);
    set_sq(s, 4'd0);
    set_sq(d, placed);
    if (castle) begin
      set_sq(rf, 4'd0);
      set_sq(rt, rc);
    end
    exp_turn = ~exp_turn;
    push(1'b0, castle ? ce + 2 : ce + 1);
    repeat (4) @(posedge clk);
    #1;
    chk("sel_after_move", selected_figure, 4'd0);
  endtask

  initial begin
    int ce;
    init_model();
    do_reset();
    check_start("reset");

    // Black pawn clicked while white is to move: no selection.
    click(6'd12, dummy);
    repeat (3) @(posedge clk);
    #1;
    chk("ignore_sel", selected_figure, 4'd0);
    chk("ignore_highlight", highlight, 64'd0);

    // Pawn 52 with two targets, an illegal target, then the double push.
    possible_moves = (64'd1 << 44) | (64'd1 << 36);
    click(6'd52, ce);
    chk("pawn_sel", selected_figure, 4'd1);
    chk("pawn_pos", position, 6'd52);
    repeat (2) @(posedge clk);
    #1;
    chk("pawn_highlight", highlight, 64'h0000_1010_0000_0000);
    click(6'd20, ce);
    push(1'b1, ce);
    repeat (2) @(posedge clk);
    #1;
    chk("illegal_still_sel", selected_figure, 4'd1);
    chk("illegal_highlight", highlight, 64'h0000_1010_0000_0000);
    click(6'd36, ce);
    set_sq(6'd52, 4'd0);
    set_sq(6'd36, 4'd1);
    exp_turn = 1'b1;
    push(1'b0, ce + 1);
    repeat (4) @(posedge clk);
    #1;
    chk("pawn_sq36", board[4][4], 4'd1);
    chk("pawn_sq52", board[6][4], 4'd0);
    chk("pawn_turn", turn, 1'b1);

    // Black selects 11, then reselects 12 and pushes to 28.
    possible_moves = 64'd0;
    click(6'd11, dummy);
    repeat (3) @(posedge clk);
    #1;
    chk("resel_first", position, 6'd11);
    move(6'd12, 6'd28, 4'h7, 4'h7, 1'b0, 6'd0, 6'd0, 4'd0);

    // Clear f1/g1 for castling, black replies in between.
    move(6'd62, 6'd45, 4'h3, 4'h3, 1'b0, 6'd0, 6'd0, 4'd0);
    move(6'd1,  6'd18, 4'h9, 4'h9, 1'b0, 6'd0, 6'd0, 4'd0);
    move(6'd61, 6'd44, 4'h2, 4'h2, 1'b0, 6'd0, 6'd0, 4'd0);
    move(6'd6,  6'd21, 4'h9, 4'h9, 1'b0, 6'd0, 6'd0, 4'd0);

    // White king-side castle.
    move(6'd60, 6'd62, 4'h6, 4'h6, 1'b1, 6'd63, 6'd61, 4'h4);
    chk("castle_king", board[7][6], 4'h6);
    chk("castle_rook", board[7][5], 4'h4);
    chk("castle_h1", board[7][7], 4'h0);
    chk("castle_e1", board[7][4], 4'h0);

    // Promotions for both colours.
    move(6'd0,  6'd16, 4'hA, 4'hA, 1'b0, 6'd0, 6'd0, 4'd0);
    move(6'd48, 6'd8,  4'h1, 4'h1, 1'b0, 6'd0, 6'd0, 4'd0);
    move(6'd9,  6'd25, 4'h7, 4'h7, 1'b0, 6'd0, 6'd0, 4'd0);
    move(6'd8,  6'd0,  4'h1, 4'h5, 1'b0, 6'd0, 6'd0, 4'd0);
    chk("promo_white", board[0][0], 4'h5);
    move(6'd15, 6'd55, 4'h7, 4'h7, 1'b0, 6'd0, 6'd0, 4'd0);
    move(6'd49, 6'd41, 4'h1, 4'h1, 1'b0, 6'd0, 6'd0, 4'd0);
    move(6'd55, 6'd63, 4'h7, 4'hB, 1'b0, 6'd0, 6'd0, 4'd0);
    chk("promo_black", board[7][7], 4'hB);
    chk("promo_turn", turn, 1'b0);

    // Reset while SELECTED.
    possible_moves = 64'd1 << 42;
    click(6'd50, dummy);
    repeat (3) @(posedge clk);
    #1;
    chk("presel_sel", selected_figure, 4'd1);
    do_reset();
    check_start("rst_selected");

    // Reset while EXEC: the move must not land and no pulse may appear.
    possible_moves = 64'd1 << 36;
    click(6'd52, dummy);
    repeat (3) @(posedge clk);
    #1;
    click(6'd36, ce);
    do_reset();
    check_start("rst_exec");
    repeat (6) @(posedge clk);
    #1;
    chk("rst_exec_board_late", board, mb);

    chk("pending_events", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
